// File: rtl/pcs_tx_symbol_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_symbol_scheduler_if
// Description : Gasket-side symbol handshake, control requests and encoder
//               outputs of the PCS TX symbol scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface pcs_tx_symbol_scheduler_if;
    logic [7:0] In_Data;
    logic       In_DataK;
    logic       In_Valid;
    logic       In_Ready;
    logic       TxElecIdle;
    logic       Tx_Compliance;
    logic [7:0] Out_Data;
    logic       Out_DataK;
    logic       Out_Valid;
    logic       Skp_Inserted;

    modport master (
        output In_Data, In_DataK, In_Valid, TxElecIdle, Tx_Compliance,
        input  In_Ready, Out_Data, Out_DataK, Out_Valid, Skp_Inserted
    );

    modport slave (
        input  In_Data, In_DataK, In_Valid, TxElecIdle, Tx_Compliance,
        output In_Ready, Out_Data, Out_DataK, Out_Valid, Skp_Inserted
    );
endinterface
`default_nettype wire

// File: rtl/pcs_tx_symbol_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pcs_tx_symbol_scheduler
// Description : Byte-rate TX scheduler: MAC pass-through, SKP ordered-set
//               insertion at packet boundaries, compliance pattern, idle blank.
// Revision    : 1.0 - initial release
// ============================================================================
module pcs_tx_symbol_scheduler #(
    parameter int SKP_INTERVAL = 1180,
    parameter int SKP_COUNT    = 3,
    parameter int CNT_W        = 11
) (
    input  wire logic                 Bit_Rate_Clk_10,
    input  wire logic                 RST_n,
    pcs_tx_symbol_scheduler_if.slave  bus
);

    localparam logic [7:0]       c_COM      = 8'hBC;
    localparam logic [7:0]       c_SKP      = 8'h1C;
    localparam logic [7:0]       c_STP      = 8'hFB;
    localparam logic [7:0]       c_SDP      = 8'h5C;
    localparam logic [7:0]       c_END      = 8'hFD;
    localparam logic [7:0]       c_EDB      = 8'hFE;
    localparam logic [2:0]       c_SKP_LAST = 3'(SKP_COUNT);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SKP_INTERVAL - 1);

    typedef enum logic [1:0] {
        ST_ELEC_IDLE = 2'd0,
        ST_DATA      = 2'd1,
        ST_SKP       = 2'd2,
        ST_COMPL     = 2'd3
    } state_t;

    state_t           r_state,    w_state;
    logic [2:0]       r_sub,      w_sub;
    logic [CNT_W-1:0] r_cnt,      w_cnt;
    logic             r_in_packet, w_in_packet;
    logic             r_skp_due,  w_skp_due;
    logic [7:0]       r_out_data, w_out_data;
    logic             r_out_k,    w_out_k;
    logic             r_out_valid, w_out_valid;
    logic             r_skp_ins,  w_skp_ins;

    logic w_ready;
    logic w_accept;
    logic w_pkt_start;
    logic w_pkt_end;

    // Back-pressure one cycle ahead of the COM so the due SKP set owns the next edge
    assign w_ready     = (r_state == ST_DATA) && !(r_skp_due && !r_in_packet);
    assign w_accept    = bus.In_Valid && w_ready;
    assign w_pkt_start = w_accept && bus.In_DataK && (bus.In_Data == c_STP || bus.In_Data == c_SDP);
    assign w_pkt_end   = w_accept && bus.In_DataK && (bus.In_Data == c_END || bus.In_Data == c_EDB);

    always_ff @(posedge Bit_Rate_Clk_10 or negedge RST_n) begin
        if (!RST_n) begin
            r_state     <= ST_ELEC_IDLE;
            r_sub       <= 3'd0;
            r_cnt       <= '0;
            r_in_packet <= 1'b0;
            r_skp_due   <= 1'b0;
            r_out_data  <= 8'h00;
            r_out_k     <= 1'b0;
            r_out_valid <= 1'b0;
            r_skp_ins   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sub       <= w_sub;
            r_cnt       <= w_cnt;
            r_in_packet <= w_in_packet;
            r_skp_due   <= w_skp_due;
            r_out_data  <= w_out_data;
            r_out_k     <= w_out_k;
            r_out_valid <= w_out_valid;
            r_skp_ins   <= w_skp_ins;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_sub       = r_sub;
        w_cnt       = r_cnt;
        w_in_packet = r_in_packet;
        w_skp_due   = r_skp_due;
        w_out_data  = 8'h00;
        w_out_k     = 1'b0;
        w_out_valid = 1'b0;
        w_skp_ins   = 1'b0;

        case (r_state)
            ST_ELEC_IDLE: begin
                w_cnt       = '0;
                w_in_packet = 1'b0;
                w_skp_due   = 1'b0;
                if (!bus.TxElecIdle) begin
                    w_sub   = 3'd0;
                    w_state = bus.Tx_Compliance ? ST_COMPL : ST_DATA;
                end
            end

            ST_DATA: begin
                if (bus.TxElecIdle) begin
                    w_state     = ST_ELEC_IDLE;
                    w_in_packet = 1'b0;
                    w_cnt       = '0;
                    w_skp_due   = 1'b0;
                end else if (bus.Tx_Compliance && !r_in_packet) begin
                    // The symbol accepted this cycle still goes out before the pattern starts
                    w_state     = ST_COMPL;
                    w_sub       = 3'd0;
                    w_cnt       = '0;
                    w_skp_due   = 1'b0;
                    w_in_packet = 1'b0;
                    w_out_valid = 1'b1;
                    if (w_accept) begin
                        w_out_data = bus.In_Data;
                        w_out_k    = bus.In_DataK;
                    end
                end else if (r_skp_due && !r_in_packet) begin
                    w_state     = ST_SKP;
                    w_sub       = 3'd1;
                    w_cnt       = '0;
                    w_skp_due   = 1'b0;
                    w_out_data  = c_COM;
                    w_out_k     = 1'b1;
                    w_out_valid = 1'b1;
                    w_skp_ins   = 1'b1;
                end else begin
                    w_out_valid = 1'b1;
                    if (w_accept) begin
                        w_out_data = bus.In_Data;
                        w_out_k    = bus.In_DataK;
                    end
                    if (w_pkt_start) begin
                        w_in_packet = 1'b1;
                    end else if (w_pkt_end) begin
                        w_in_packet = 1'b0;
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        w_skp_due = 1'b1;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end

            ST_SKP: begin
                w_out_data  = c_SKP;
                w_out_k     = 1'b1;
                w_out_valid = 1'b1;
                if (r_sub == c_SKP_LAST) begin
                    w_sub   = 3'd0;
                    w_state = bus.TxElecIdle ? ST_ELEC_IDLE : ST_DATA;
                end else begin
                    w_sub = r_sub + 3'd1;
                end
            end

            ST_COMPL: begin
                w_cnt       = '0;
                w_skp_due   = 1'b0;
                w_out_valid = 1'b1;
                case (r_sub[1:0])
                    2'd0:    begin w_out_data = 8'hBC; w_out_k = 1'b1; end
                    2'd1:    begin w_out_data = 8'hB5; w_out_k = 1'b0; end
                    2'd2:    begin w_out_data = 8'hBC; w_out_k = 1'b1; end
                    default: begin w_out_data = 8'h4A; w_out_k = 1'b0; end
                endcase
                // Requests are only honoured on a group boundary
                if (r_sub[1:0] == 2'd3) begin
                    w_sub = 3'd0;
                    if (bus.TxElecIdle) begin
                        w_state = ST_ELEC_IDLE;
                    end else if (!bus.Tx_Compliance) begin
                        w_state = ST_DATA;
                    end
                end else begin
                    w_sub = r_sub + 3'd1;
                end
            end

            default: w_state = ST_ELEC_IDLE;
        endcase
    end

    assign bus.In_Ready     = w_ready;
    assign bus.Out_Data     = r_out_data;
    assign bus.Out_DataK    = r_out_k;
    assign bus.Out_Valid    = r_out_valid;
    assign bus.Skp_Inserted = r_skp_ins;

endmodule
`default_nettype wire
